// File: rtl/reaction_timer_multi.sv
// reaction_timer_multi: multi-round reaction timer for the board top level.
// Runs ROUNDS trials after pseudo-random delays, accumulates reaction times,
// then shows the truncated average on digits 3..0 of the 8-digit display.
// Optional feature macro: RT_BEST_EN (best time tracked and shown on digits 7..4).
module reaction_timer_multi #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int ROUNDS       = 4,
  parameter int MIN_DELAY_MS = 2000,
  parameter int MAX_DELAY_MS = 15000,
  parameter int TIMEOUT_MS   = 1000
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic        BTNC,
  input  logic        BTNU,
  output logic [15:0] LED,
  output logic [7:0]  AN,
  output logic        CA,
  output logic        CB,
  output logic        CC,
  output logic        CD,
  output logic        CE,
  output logic        CF,
  output logic        CG,
  output logic        DP
);

  localparam int TICK_DIV   = CLK_HZ / 1000;
  localparam int PRE_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW         = $clog2(ROUNDS + 1);
  localparam int SW         = 14 + RW;
  localparam int DELAY_SPAN = MAX_DELAY_MS - MIN_DELAY_MS + 1;
  localparam logic [13:0] SAT = 14'd9999;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_REACT, S_ROUND_DONE, S_SUMMARY, S_FAULT
  } state_t;

  genvar gi;

  // Button conditioning: bit 0 = BTNC, bit 1 = BTNU; registered edge pulse
  logic [1:0] btn_meta_reg, btn_sync_reg, btn_prev_reg, btn_edge_reg;
  logic       btnc_edge, btnu_edge;
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      btn_meta_reg <= '0;
      btn_sync_reg <= '0;
      btn_prev_reg <= '0;
      btn_edge_reg <= '0;
    end else begin
      btn_meta_reg <= {BTNU, BTNC};
      btn_sync_reg <= btn_meta_reg;
      btn_prev_reg <= btn_sync_reg;
      btn_edge_reg <= btn_sync_reg & ~btn_prev_reg;
    end
  end
  assign btnc_edge = btn_edge_reg[0];
  assign btnu_edge = btn_edge_reg[1];

  // Millisecond prescaler and display scan index
  logic [PRE_W-1:0] pre_cnt_reg;
  logic             ms_tick;
  logic [2:0]       an_idx_reg;
  assign ms_tick = (pre_cnt_reg == PRE_W'(TICK_DIV - 1));
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      pre_cnt_reg <= '0;
      an_idx_reg  <= 3'd0;
    end else if (ms_tick) begin
      pre_cnt_reg <= '0;
      an_idx_reg  <= an_idx_reg + 3'd1;
    end else begin
      pre_cnt_reg <= pre_cnt_reg + PRE_W'(1);
    end
  end

  // Free-running LFSR (x^16 + x^14 + x^13 + x^11 + 1); only the board reset reseeds it
  logic [15:0] lfsr_reg;
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) lfsr_reg <= 16'hACE1;
    else             lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
  end

  logic [15:0] delay_calc;
  assign delay_calc = 16'(32'(MIN_DELAY_MS) + (32'(lfsr_reg) % 32'(DELAY_SPAN)));

  state_t          state_reg, state_next;
  logic [RW-1:0]   round_reg, round_next;
  logic [SW-1:0]   sum_reg, sum_next;
  logic [13:0]     last_reg, last_next;
  logic [15:0]     delay_reg, delay_next;
  logic [15:0]     ms_cnt_reg;
  logic [15:0]     led_reg;
  logic [15:0]     thermo_next;
  logic [13:0]     react_ms;
`ifdef RT_BEST_EN
  logic [13:0]     best_reg, best_next;
`endif

  // A press wins over a simultaneous timeout and records the current count
  assign react_ms = btnc_edge ? ms_cnt_reg[13:0] : 14'(TIMEOUT_MS);

  // Next-state and datapath update; clear has priority over everything
  always_comb begin
    state_next = state_reg;
    round_next = round_reg;
    sum_next   = sum_reg;
    last_next  = last_reg;
    delay_next = delay_reg;
`ifdef RT_BEST_EN
    best_next  = best_reg;
`endif
    if (btnu_edge) begin
      state_next = S_IDLE;
      round_next = '0;
      sum_next   = '0;
      last_next  = '0;
`ifdef RT_BEST_EN
      best_next  = SAT;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          round_next = '0;
          sum_next   = '0;
          if (btnc_edge) begin
            state_next = S_WAIT;
            delay_next = delay_calc;
          end
        end
        S_WAIT: begin
          if (btnc_edge)                    state_next = S_FAULT;
          else if (ms_cnt_reg == delay_reg) state_next = S_REACT;
        end
        S_REACT: begin
          if (btnc_edge || ms_cnt_reg == 16'(TIMEOUT_MS)) begin
            state_next = S_ROUND_DONE;
            last_next  = react_ms;
            sum_next   = sum_reg + SW'(react_ms);
            round_next = round_reg + RW'(1);
`ifdef RT_BEST_EN
            if (react_ms < best_reg) best_next = react_ms;
`endif
          end
        end
        S_ROUND_DONE: begin
          if (btnc_edge) begin
            if (round_reg == RW'(ROUNDS)) begin
              state_next = S_SUMMARY;
            end else begin
              state_next = S_WAIT;
              delay_next = delay_calc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Thermometer of completed rounds, taken from the next round count
  for (gi = 0; gi < 16; gi++) begin : g_thermo
    assign thermo_next[gi] = (int'(round_next) > gi);
  end

  // State registers; ms_cnt restarts on every state change
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_reg  <= S_IDLE;
      round_reg  <= '0;
      sum_reg    <= '0;
      last_reg   <= '0;
      delay_reg  <= '0;
      ms_cnt_reg <= '0;
      led_reg    <= '0;
`ifdef RT_BEST_EN
      best_reg   <= SAT;
`endif
    end else begin
      state_reg <= state_next;
      round_reg <= round_next;
      sum_reg   <= sum_next;
      last_reg  <= last_next;
      delay_reg <= delay_next;
`ifdef RT_BEST_EN
      best_reg  <= best_next;
`endif
      if (state_next != state_reg) ms_cnt_reg <= '0;
      else if (ms_tick)            ms_cnt_reg <= ms_cnt_reg + 16'd1;
      if (state_next == S_REACT)      led_reg <= 16'hFFFF;
      else if (state_next == S_FAULT) led_reg <= 16'hAAAA;
      else                            led_reg <= thermo_next;
    end
  end
  assign LED = led_reg;

  logic [SW-1:0] avg;
  logic [13:0]   avg_sat;
  assign avg     = sum_reg / SW'(ROUNDS);
  assign avg_sat = (avg > SW'(9999)) ? SAT : avg[13:0];

  // Content of the low four digits per state
  logic [13:0] lo_val, hi_val;
  logic        lo_blank, lo_dash, hi_blank;
  always_comb begin
    lo_val   = '0;
    lo_blank = 1'b1;
    lo_dash  = 1'b0;
    case (state_reg)
      S_IDLE:       begin lo_dash = 1'b1; lo_blank = 1'b0; end
      S_ROUND_DONE: begin lo_val = (last_reg > SAT) ? SAT : last_reg; lo_blank = 1'b0; end
      S_SUMMARY:    begin lo_val = avg_sat; lo_blank = 1'b0; end
      S_FAULT:      begin lo_val = SAT; lo_blank = 1'b0; end
      default: ;
    endcase
  end

`ifdef RT_BEST_EN
  assign hi_val   = (best_reg > SAT) ? SAT : best_reg;
  assign hi_blank = !(state_reg == S_ROUND_DONE || state_reg == S_SUMMARY);
`else
  assign hi_val   = '0;
  assign hi_blank = 1'b1;
`endif

  // Digit selection and seven-segment decode for the digit being scanned
  logic [13:0] cur_val, cur_div;
  logic        cur_blank, cur_dash;
  logic [3:0]  cur_digit;
  logic [6:0]  seg_on;
  always_comb begin
    cur_val   = an_idx_reg[2] ? hi_val   : lo_val;
    cur_blank = an_idx_reg[2] ? hi_blank : lo_blank;
    cur_dash  = an_idx_reg[2] ? 1'b0     : lo_dash;
    case (an_idx_reg[1:0])
      2'd0:    cur_div = 14'd1;
      2'd1:    cur_div = 14'd10;
      2'd2:    cur_div = 14'd100;
      default: cur_div = 14'd1000;
    endcase
    cur_digit = 4'((cur_val / cur_div) % 14'd10);
    case (cur_digit)
      4'd0:    seg_on = 7'b1111110;
      4'd1:    seg_on = 7'b0110000;
      4'd2:    seg_on = 7'b1101101;
      4'd3:    seg_on = 7'b1111001;
      4'd4:    seg_on = 7'b0110011;
      4'd5:    seg_on = 7'b1011011;
      4'd6:    seg_on = 7'b1011111;
      4'd7:    seg_on = 7'b1110000;
      4'd8:    seg_on = 7'b1111111;
      default: seg_on = 7'b1111011;
    endcase
    if (cur_blank)     seg_on = 7'b0000000;
    else if (cur_dash) seg_on = 7'b0000001;
  end
  assign {CA, CB, CC, CD, CE, CF, CG} = ~seg_on;
  assign DP = 1'b1;

  for (gi = 0; gi < 8; gi++) begin : g_anode
    assign AN[gi] = (an_idx_reg != 3'(gi));
  end

endmodule

// File: tb/tb_reaction_timer_multi.sv
// Self-checking bench for reaction_timer_multi with 1 clock per ms.
module tb_reaction_timer_multi;
  localparam int P_ROUNDS  = 2;
  localparam int P_MIN     = 2;
  localparam int P_MAX     = 5;
  localparam int P_TIMEOUT = 10;
`ifdef RT_BEST_EN
  localparam bit BEST = 1'b1;
`else
  localparam bit BEST = 1'b0;
`endif

  logic        CLK100MHZ = 1'b0;
  logic        CPU_RESETN = 1'b0;
  logic        BTNC = 1'b0;
  logic        BTNU = 1'b0;
  logic [15:0] LED;
  logic [7:0]  AN;
  logic        CA, CB, CC, CD, CE, CF, CG, DP;

  reaction_timer_multi #(
    .CLK_HZ(1000), .ROUNDS(P_ROUNDS), .MIN_DELAY_MS(P_MIN),
    .MAX_DELAY_MS(P_MAX), .TIMEOUT_MS(P_TIMEOUT)
  ) dut (
    .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN), .BTNC(BTNC), .BTNU(BTNU),
    .LED(LED), .AN(AN), .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE),
    .CF(CF), .CG(CG), .DP(DP)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  typedef enum {A_START, A_REACT, A_TIMEOUT, A_C, A_CLEAR, A_EARLY, A_BOTH} act_t;
  typedef struct {
    act_t        act;
    int          ms;
    logic [15:0] led;
    logic [15:0] lo;
    logic [15:0] hi;
    bit          disp;
    string       name;
  } vec_t;
  typedef struct {
    string       name;
    logic [15:0] led;
    logic [15:0] lo;
    logic [15:0] hi;
    bit          disp;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK100MHZ);
      #1;
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Digit code: 0..9 numerals, A dash, B blank, E unrecognised, F never scanned
  function automatic logic [3:0] seg_code(input logic [6:0] s);
    case (s)
      7'b0000001: return 4'h0;
      7'b1001111: return 4'h1;
      7'b0010010: return 4'h2;
      7'b0000110: return 4'h3;
      7'b1001100: return 4'h4;
      7'b0100100: return 4'h5;
      7'b0100000: return 4'h6;
      7'b0001111: return 4'h7;
      7'b0000000: return 4'h8;
      7'b0000100: return 4'h9;
      7'b1111110: return 4'hA;
      7'b1111111: return 4'hB;
      default:    return 4'hE;
    endcase
  endfunction

  task automatic read_display(output logic [15:0] lo, output logic [15:0] hi);
    logic [3:0] codes [8];
    for (int i = 0; i < 8; i++) codes[i] = 4'hF;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 8; i++)
        if (AN[i] == 1'b0) codes[i] = seg_code({CA, CB, CC, CD, CE, CF, CG});
      tick(1);
    end
    lo = {codes[3], codes[2], codes[1], codes[0]};
    hi = {codes[7], codes[6], codes[5], codes[4]};
  endtask

  // Press lasts one cycle; the new state is visible after the 4th edge
  task automatic press_c();
    BTNC = 1'b1; tick(1); BTNC = 1'b0; tick(3);
  endtask

  task automatic press_u();
    BTNU = 1'b1; tick(1); BTNU = 1'b0; tick(3);
  endtask

  // Waits for LED to go all-on; delay+1 cycles after entering WAIT
  task automatic wait_react();
    int n = 0;
    while (LED !== 16'hFFFF && n < 200) begin
      tick(1);
      n++;
    end
    checks++;
    if (LED !== 16'hFFFF) begin
      errors++;
      $display("FAIL react_entry: LED=%h after %0d cycles, required FFFF", LED, n);
    end else if (n < P_MIN + 1 || n > P_MAX + 1) begin
      errors++;
      $display("FAIL delay_range: REACT after %0d cycles, required %0d..%0d", n, P_MIN + 1, P_MAX + 1);
    end else begin
      $display("ok   react_entry after %0d cycles", n);
    end
  endtask

  task automatic compare_out();
    exp_t        e;
    logic [15:0] lo, hi;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: queue empty, required one entry");
      return;
    end
    e = exp_q.pop_front();
    check16({e.name, "/led"}, LED, e.led);
    if (e.disp) begin
      read_display(lo, hi);
      check16({e.name, "/lo"}, lo, e.lo);
      check16({e.name, "/hi"}, hi, e.hi);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    exp_t e;
    int   n;
    e.name = v.name;
    e.led  = v.led;
    e.lo   = v.lo;
    e.hi   = BEST ? v.hi : 16'hBBBB;
    e.disp = v.disp;
    exp_q.push_back(e);
    case (v.act)
      A_START, A_C: press_c();
      A_CLEAR:      press_u();
      A_REACT: begin
        wait_react();
        tick(v.ms - 3);
        press_c();
      end
      A_TIMEOUT: begin
        wait_react();
        n = 0;
        while (LED === 16'hFFFF && n < 50) begin
          tick(1);
          n++;
        end
        check16({v.name, "/cycles"}, 16'(n), 16'(P_TIMEOUT + 1));
      end
      A_EARLY: begin
        BTNC = 1'b1; tick(1); BTNC = 1'b0; tick(1);
        BTNC = 1'b1; tick(1); BTNC = 1'b0; tick(3);
      end
      A_BOTH: begin
        wait_react();
        BTNC = 1'b1; BTNU = 1'b1; tick(1);
        BTNC = 1'b0; BTNU = 1'b0; tick(3);
      end
      default: ;
    endcase
    compare_out();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t hv;
    // Expected display codes: hex nibbles of decimal digits, A = dash, B = blank
    vecs.push_back('{A_START,   0, 16'h0000, 16'h0000, 16'h0000, 1'b0, "s1_start1"});
    vecs.push_back('{A_REACT,   3, 16'h0001, 16'h0003, 16'h0003, 1'b1, "s1_react3"});
    vecs.push_back('{A_START,   0, 16'h0001, 16'h0000, 16'h0000, 1'b0, "s1_start2"});
    vecs.push_back('{A_REACT,   6, 16'h0003, 16'h0006, 16'h0003, 1'b1, "s1_react6"});
    vecs.push_back('{A_C,       0, 16'h0003, 16'h0004, 16'h0003, 1'b1, "s1_summary"});
    vecs.push_back('{A_CLEAR,   0, 16'h0000, 16'hAAAA, 16'hBBBB, 1'b1, "clear1"});
    vecs.push_back('{A_EARLY,   0, 16'hAAAA, 16'h9999, 16'hBBBB, 1'b1, "early_fault"});
    vecs.push_back('{A_C,       0, 16'hAAAA, 16'h9999, 16'hBBBB, 1'b1, "fault_ignores_c"});
    vecs.push_back('{A_CLEAR,   0, 16'h0000, 16'hAAAA, 16'hBBBB, 1'b1, "fault_clear"});
    vecs.push_back('{A_START,   0, 16'h0000, 16'h0000, 16'h0000, 1'b0, "s2_start1"});
    vecs.push_back('{A_TIMEOUT, 0, 16'h0001, 16'h0010, 16'h0010, 1'b1, "s2_timeout"});
    vecs.push_back('{A_START,   0, 16'h0001, 16'h0000, 16'h0000, 1'b0, "s2_start2"});
    vecs.push_back('{A_REACT,  10, 16'h0003, 16'h0010, 16'h0010, 1'b1, "s2_press_at_timeout"});
    vecs.push_back('{A_C,       0, 16'h0003, 16'h0010, 16'h0010, 1'b1, "s2_summary"});
    vecs.push_back('{A_CLEAR,   0, 16'h0000, 16'hAAAA, 16'hBBBB, 1'b1, "clear2"});
    vecs.push_back('{A_START,   0, 16'h0000, 16'h0000, 16'h0000, 1'b0, "s3_start1"});
    vecs.push_back('{A_REACT,   4, 16'h0001, 16'h0004, 16'h0004, 1'b1, "s3_react4"});
    vecs.push_back('{A_START,   0, 16'h0001, 16'h0000, 16'h0000, 1'b0, "s3_start2"});
    vecs.push_back('{A_BOTH,    0, 16'h0000, 16'hAAAA, 16'hBBBB, 1'b1, "s3_both_clear"});
    vecs.push_back('{A_START,   0, 16'h0000, 16'h0000, 16'h0000, 1'b0, "s4_start1"});
    vecs.push_back('{A_REACT,   5, 16'h0001, 16'h0005, 16'h0005, 1'b1, "s4_react5"});
    vecs.push_back('{A_START,   0, 16'h0001, 16'h0000, 16'h0000, 1'b0, "s4_start2"});
    vecs.push_back('{A_REACT,   8, 16'h0003, 16'h0008, 16'h0005, 1'b1, "s4_react8"});
    vecs.push_back('{A_C,       0, 16'h0003, 16'h0006, 16'h0005, 1'b1, "s4_summary"});

    // Reset state and scan wrap
    CPU_RESETN = 1'b0;
    tick(3);
    check16("rst_led", LED, 16'h0000);
    check16("rst_an", {8'h00, AN}, 16'h00FE);
    check16("rst_seg", {8'h00, CA, CB, CC, CD, CE, CF, CG, DP}, 16'h00FD);
    CPU_RESETN = 1'b1;
    tick(1);
    check16("scan_step", {8'h00, AN}, 16'h00FD);
    tick(7);
    check16("scan_wrap", {8'h00, AN}, 16'h00FE);

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i]);

    // Asynchronous reset in ROUND_DONE, then a clean session
    hv = '{A_CLEAR, 0, 16'h0000, 16'hAAAA, 16'hBBBB, 1'b1, "m_clear"};
    apply_vec(hv);
    hv = '{A_START, 0, 16'h0000, 16'h0000, 16'h0000, 1'b0, "m_start"};
    apply_vec(hv);
    hv = '{A_REACT, 7, 16'h0001, 16'h0007, 16'h0007, 1'b1, "m_react7"};
    apply_vec(hv);
    #2;
    CPU_RESETN = 1'b0;
    #1;
    check16("midrst_led", LED, 16'h0000);
    check16("midrst_an", {8'h00, AN}, 16'h00FE);
    check16("midrst_seg", {8'h00, CA, CB, CC, CD, CE, CF, CG, DP}, 16'h00FD);
    tick(2);
    CPU_RESETN = 1'b1;
    tick(1);
    hv = '{A_START, 0, 16'h0000, 16'h0000, 16'h0000, 1'b0, "post_start"};
    apply_vec(hv);
    hv = '{A_REACT, 8, 16'h0001, 16'h0008, 16'h0008, 1'b1, "post_react8"};
    apply_vec(hv);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
